// File: rtl/alu_sequencer_pkg.sv
// Shared opcode, unit-select and state definitions for the ALU sequencer.
// Opcode values double as bit positions in the one-hot strobe vector.
package alu_sequencer_pkg;

  localparam int NUM_OPS = 13;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_LSL = 4'd10;
  localparam logic [3:0] OP_LSR = 4'd11;
  localparam logic [3:0] OP_ASR = 4'd12;

  localparam logic [2:0] SEL_ADDER = 3'd0;
  localparam logic [2:0] SEL_MUL   = 3'd1;
  localparam logic [2:0] SEL_DIV   = 3'd2;
  localparam logic [2:0] SEL_MOV   = 3'd3;
  localparam logic [2:0] SEL_LOGIC = 3'd4;
  localparam logic [2:0] SEL_SHIFT = 3'd5;

  typedef enum logic [2:0] {ST_CLR, ST_IDLE, ST_LOAD, ST_EXEC, ST_WB} state_e;
  typedef enum logic [1:0] {LAT_ONE, LAT_MUL, LAT_DIV} lat_e;

  typedef struct packed {
    logic [2:0]         alu_sel;
    logic [NUM_OPS-1:0] strb;
    lat_e               lat;
    logic               is_cmp;
    logic               legal;
  } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: unit select, one-hot strobe, latency class,
// compare flag and legality.
module alu_op_decode
  import alu_sequencer_pkg::*;
(
  input  logic [3:0] i_op,
  output dec_t       o_dec
);

  logic w_legal;
  assign w_legal = (i_op < 4'(NUM_OPS));

  always_comb begin
    o_dec        = '0;
    o_dec.lat    = LAT_ONE;
    o_dec.legal  = w_legal;
    o_dec.is_cmp = (i_op == OP_CMP);
    if (w_legal) o_dec.strb = NUM_OPS'(1) << i_op;
    case (i_op)
      OP_ADD, OP_SUB, OP_CMP: o_dec.alu_sel = SEL_ADDER;
      OP_MUL: begin
        o_dec.alu_sel = SEL_MUL;
        o_dec.lat     = LAT_MUL;
      end
      OP_DIV, OP_MOD: begin
        o_dec.alu_sel = SEL_DIV;
        o_dec.lat     = LAT_DIV;
      end
      OP_MOV:                 o_dec.alu_sel = SEL_MOV;
      OP_AND, OP_OR, OP_NOT:  o_dec.alu_sel = SEL_LOGIC;
      OP_LSL, OP_LSR, OP_ASR: o_dec.alu_sel = SEL_SHIFT;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// ALU control sequencer: CLR -> IDLE -> LOAD -> EXEC(L cycles) -> WB, with
// flush back to CLR and CMP finishing straight out of EXEC with a flag write.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int MUL_LAT = 1,
  parameter int DIV_LAT = 4,
  parameter int RDW     = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     in_op,
  input  logic           in_imm,
  input  logic [RDW-1:0] in_rd,
  input  logic           flush,
  output logic           ldA,
  output logic           ldB,
  output logic           clrA,
  output logic           clrB,
  output logic           ldResult,
  output logic           clrResult,
  output logic           isImmediate,
  output logic [2:0]     aluSel,
  output logic           isAdd,
  output logic           isSub,
  output logic           isCmp,
  output logic           isMul,
  output logic           isDiv,
  output logic           isMod,
  output logic           isMov,
  output logic           isAnd,
  output logic           isOr,
  output logic           isNot,
  output logic           isLsl,
  output logic           isLsr,
  output logic           isAsr,
  output logic           wrFlag,
  output logic           wb_en,
  output logic [RDW-1:0] wb_rd,
  output logic           done,
  output logic           err
);

  localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL) + 1;

  state_e             r_state, w_next;
  logic [CW-1:0]      r_cnt, w_lat_val;
  logic [NUM_OPS-1:0] r_strb, w_strb;
  logic [2:0]         r_alusel;
  lat_e               r_lat;
  logic               r_cmp, r_imm;
  logic [RDW-1:0]     r_rd;
  dec_t               w_dec;
  logic               w_accept;

  alu_op_decode u_dec (
    .i_op  (in_op),
    .o_dec (w_dec)
  );

  assign w_accept = (r_state == ST_IDLE) && in_valid && !flush && w_dec.legal;

  always_comb begin
    case (r_lat)
      LAT_MUL: w_lat_val = CW'(MUL_LAT);
      LAT_DIV: w_lat_val = CW'(DIV_LAT);
      default: w_lat_val = CW'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_CLR;
    else     r_state <= w_next;
  end

  // Decoded fields are captured at accept so LOAD/EXEC never re-decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_strb   <= '0;
      r_alusel <= SEL_ADDER;
      r_lat    <= LAT_ONE;
      r_cmp    <= 1'b0;
      r_imm    <= 1'b0;
      r_rd     <= '0;
    end else begin
      if (w_accept) begin
        r_strb   <= w_dec.strb;
        r_alusel <= w_dec.alu_sel;
        r_lat    <= w_dec.lat;
        r_cmp    <= w_dec.is_cmp;
        r_imm    <= in_imm;
        r_rd     <= in_rd;
      end
      if (r_state == ST_LOAD)      r_cnt <= w_lat_val;
      else if (r_state == ST_EXEC) r_cnt <= r_cnt - CW'(1);
    end
  end

  always_comb begin
    w_next      = r_state;
    in_ready    = 1'b0;
    ldA         = 1'b0;
    ldB         = 1'b0;
    clrA        = 1'b0;
    clrB        = 1'b0;
    clrResult   = 1'b0;
    ldResult    = 1'b0;
    isImmediate = 1'b0;
    w_strb      = '0;
    wrFlag      = 1'b0;
    wb_en       = 1'b0;
    wb_rd       = '0;
    done        = 1'b0;
    err         = 1'b0;
    case (r_state)
      ST_CLR: begin
        clrA      = 1'b1;
        clrB      = 1'b1;
        clrResult = 1'b1;
        w_next    = ST_IDLE;
      end
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          if (w_dec.legal) w_next = ST_LOAD;
          else             err    = 1'b1;
        end
      end
      ST_LOAD: begin
        ldA         = 1'b1;
        ldB         = 1'b1;
        isImmediate = r_imm;
        w_strb      = r_strb;
        w_next      = flush ? ST_CLR : ST_EXEC;
      end
      ST_EXEC: begin
        isImmediate = r_imm;
        w_strb      = r_strb;
        if (flush) begin
          w_next = ST_CLR;
        end else if (r_cnt == CW'(1)) begin
          if (r_cmp) begin
            wrFlag = 1'b1;
            done   = 1'b1;
            w_next = ST_IDLE;
          end else begin
            ldResult = 1'b1;
            w_next   = ST_WB;
          end
        end
      end
      ST_WB: begin
        if (flush) begin
          w_next = ST_CLR;
        end else begin
          wb_en  = 1'b1;
          wb_rd  = r_rd;
          done   = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_CLR;
    endcase
  end

  assign aluSel = r_alusel;
  assign isAdd  = w_strb[OP_ADD];
  assign isSub  = w_strb[OP_SUB];
  assign isMul  = w_strb[OP_MUL];
  assign isDiv  = w_strb[OP_DIV];
  assign isMod  = w_strb[OP_MOD];
  assign isCmp  = w_strb[OP_CMP];
  assign isAnd  = w_strb[OP_AND];
  assign isOr   = w_strb[OP_OR];
  assign isNot  = w_strb[OP_NOT];
  assign isMov  = w_strb[OP_MOV];
  assign isLsl  = w_strb[OP_LSL];
  assign isLsr  = w_strb[OP_LSR];
  assign isAsr  = w_strb[OP_ASR];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: per-cycle timeline reference model, directed table
// of single transactions, hand sequences for flush/reset/illegal, random traffic.
module tb_alu_sequencer;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 4;
  localparam int RDW     = 5;

  localparam int PH_CLR  = 0;
  localparam int PH_IDLE = 1;
  localparam int PH_BUSY = 2;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_imm, flush;
  logic [3:0] in_op;
  logic [RDW-1:0] in_rd;
  logic in_ready, ldA, ldB, clrA, clrB, ldResult, clrResult, isImmediate;
  logic [2:0] aluSel;
  logic isAdd, isSub, isCmp, isMul, isDiv, isMod, isMov, isAnd, isOr, isNot, isLsl, isLsr, isAsr;
  logic wrFlag, wb_en, done, err;
  logic [RDW-1:0] wb_rd;

  always #5 clk = ~clk;

  alu_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .RDW(RDW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_imm(in_imm), .in_rd(in_rd), .flush(flush), .ldA(ldA), .ldB(ldB), .clrA(clrA),
    .clrB(clrB), .ldResult(ldResult), .clrResult(clrResult), .isImmediate(isImmediate),
    .aluSel(aluSel), .isAdd(isAdd), .isSub(isSub), .isCmp(isCmp), .isMul(isMul),
    .isDiv(isDiv), .isMod(isMod), .isMov(isMov), .isAnd(isAnd), .isOr(isOr),
    .isNot(isNot), .isLsl(isLsl), .isLsr(isLsr), .isAsr(isAsr), .wrFlag(wrFlag),
    .wb_en(wb_en), .wb_rd(wb_rd), .done(done), .err(err)
  );

  typedef struct packed {
    logic in_ready, ldA, ldB, clrA, clrB, ldResult, clrResult, isImm;
    logic [2:0]  sel;
    logic [12:0] strb;
    logic wrFlag, wb_en;
    logic [4:0] wb_rd;
    logic done, err;
  } out_t;

  logic [12:0] a_strb;
  out_t w_act;
  assign a_strb = {isAsr, isLsr, isLsl, isMov, isNot, isOr, isAnd, isCmp, isMod, isDiv, isMul, isSub, isAdd};
  assign w_act  = {in_ready, ldA, ldB, clrA, clrB, ldResult, clrResult, isImmediate, aluSel,
                   a_strb, wrFlag, wb_en, wb_rd, done, err};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  out_t last;

  // Reference model: a transaction is remembered by its accept cycle, and each
  // output is predicted from how many cycles have elapsed since then.
  int m_phase = PH_CLR, m_t = 0;
  logic [3:0] m_op = '0;
  logic m_imm = 1'b0;
  logic [4:0] m_rd = '0;
  logic [2:0] m_sel = '0;

  function automatic logic [2:0] unit_of(input logic [3:0] op);
    case (op)
      4'd2:             return 3'd1;
      4'd3, 4'd4:       return 3'd2;
      4'd9:             return 3'd3;
      4'd6, 4'd7, 4'd8: return 3'd4;
      4'd10, 4'd11, 4'd12: return 3'd5;
      default:          return 3'd0;
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    if (op == 4'd2) return MUL_LAT;
    if (op == 4'd3 || op == 4'd4) return DIV_LAT;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic cycle();
    out_t e;
    int k, L, n_phase, n_t;
    logic [3:0] n_op;
    logic n_imm;
    logic [4:0] n_rd;
    logic [2:0] n_sel;
    @(negedge clk);
    e = '0; e.sel = m_sel;
    n_phase = m_phase; n_t = m_t; n_op = m_op; n_imm = m_imm; n_rd = m_rd; n_sel = m_sel;
    case (m_phase)
      PH_CLR: begin
        e.clrA = 1'b1; e.clrB = 1'b1; e.clrResult = 1'b1;
        n_phase = PH_IDLE;
      end
      PH_IDLE: begin
        e.in_ready = 1'b1;
        if (in_valid && !flush) begin
          if (in_op <= 4'd12) begin
            n_phase = PH_BUSY; n_t = cyc; n_op = in_op; n_imm = in_imm; n_rd = in_rd;
            n_sel = unit_of(in_op);
          end else e.err = 1'b1;
        end
      end
      default: begin
        k = cyc - m_t;
        L = lat_of(m_op);
        if (k <= L + 1) begin e.strb = 13'(1) << m_op; e.isImm = m_imm; end
        if (k == 1) begin e.ldA = 1'b1; e.ldB = 1'b1; end
        if (k == L + 1 && !flush) begin
          if (m_op == 4'd5) begin e.wrFlag = 1'b1; e.done = 1'b1; n_phase = PH_IDLE; end
          else e.ldResult = 1'b1;
        end
        if (k == L + 2 && !flush) begin
          e.wb_en = 1'b1; e.wb_rd = m_rd; e.done = 1'b1; n_phase = PH_IDLE;
        end
        if (flush) n_phase = PH_CLR;
      end
    endcase
    last = w_act;
    if (chk_en) chk("model", 64'(w_act), 64'(e));
    @(posedge clk);
    if (rst) begin
      m_phase = PH_CLR; m_sel = '0; chk_en = 1'b1;
    end else begin
      m_phase = n_phase; m_t = n_t; m_op = n_op; m_imm = n_imm; m_rd = n_rd; m_sel = n_sel;
    end
    cyc++;
    #1;
  endtask

  typedef struct {
    logic [3:0] op;
    logic imm;
    logic [4:0] rd;
    int off;
    logic [2:0] sel;
    logic wb;
  } vec_t;

  vec_t tbl[10];
  out_t ev;
  int off;
  logic got, g_wb;
  logic [2:0] g_sel;
  logic [4:0] g_rd;

  initial begin
    tbl[0] = '{4'd0,  1'b0, 5'd3,  3, 3'd0, 1'b1};  // ADD
    tbl[1] = '{4'd3,  1'b1, 5'd7,  6, 3'd2, 1'b1};  // DIV imm
    tbl[2] = '{4'd5,  1'b0, 5'd9,  2, 3'd0, 1'b0};  // CMP
    tbl[3] = '{4'd2,  1'b0, 5'd1,  5, 3'd1, 1'b1};  // MUL
    tbl[4] = '{4'd4,  1'b1, 5'd30, 6, 3'd2, 1'b1};  // modulo
    tbl[5] = '{4'd9,  1'b0, 5'd12, 3, 3'd3, 1'b1};  // MOV
    tbl[6] = '{4'd8,  1'b0, 5'd0,  3, 3'd4, 1'b1};  // NOT
    tbl[7] = '{4'd12, 1'b1, 5'd31, 3, 3'd5, 1'b1};  // ASR
    tbl[8] = '{4'd1,  1'b0, 5'd4,  3, 3'd0, 1'b1};  // SUB
    tbl[9] = '{4'd10, 1'b1, 5'd5,  3, 3'd5, 1'b1};  // LSL

    in_valid = 1'b0; in_op = '0; in_imm = 1'b0; in_rd = '0; flush = 1'b0; rst = 1'b1;
    cycle(); cycle();
    chk("rst_clr", 64'({last.clrA, last.clrB, last.clrResult}), 64'(3'b111));
    chk("rst_sel", 64'(last.sel), 64'(0));
    rst = 1'b0;
    cycle();
    chk("clr_after_rst", 64'({last.clrA, last.in_ready}), 64'(2'b10));
    cycle();
    ev = '0; ev.in_ready = 1'b1;
    chk("idle_outs", 64'(last), 64'(ev));

    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_op = tbl[i].op; in_imm = tbl[i].imm; in_rd = tbl[i].rd;
      cycle();
      in_valid = 1'b0;
      got = 1'b0; off = 0; g_sel = '0; g_wb = 1'b0; g_rd = '0;
      for (int j = 1; j <= 12 && !got; j++) begin
        cycle();
        if (last.done === 1'b1) begin
          got = 1'b1; off = j; g_sel = last.sel; g_wb = last.wb_en; g_rd = last.wb_rd;
        end
      end
      chk("tbl_latency", 64'(off), 64'(tbl[i].off));
      chk("tbl_alusel", 64'(g_sel), 64'(tbl[i].sel));
      chk("tbl_wb_en", 64'(g_wb), 64'(tbl[i].wb));
      if (tbl[i].wb) chk("tbl_wb_rd", 64'(g_rd), 64'(tbl[i].rd));
      cycle();
    end

    // MUL flushed in its 2nd EXEC cycle
    in_valid = 1'b1; in_op = 4'd2; in_imm = 1'b0; in_rd = 5'd6;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("mul_load", 64'({last.ldA, last.ldB, last.strb}), 64'({2'b11, 13'b100}));
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_quiet", 64'({last.done, last.ldResult, last.wb_en}), 64'(0));
    cycle();
    chk("flush_clr", 64'({last.clrA, last.clrB, last.clrResult, last.done, last.wb_en}), 64'(5'b11100));
    cycle();
    chk("flush_idle", 64'(last.in_ready), 64'(1));

    // Illegal op, then back-to-back ADD
    in_valid = 1'b1; in_op = 4'd14;
    cycle();
    chk("illegal_err", 64'({last.err, last.in_ready}), 64'(2'b11));
    in_op = 4'd0; in_rd = 5'd2;
    cycle();
    in_valid = 1'b0;
    chk("legal_no_err", 64'(last.err), 64'(0));
    cycle();
    chk("b2b_load", 64'(last.ldA), 64'(1));
    cycle(); cycle();
    chk("b2b_done", 64'({last.done, last.wb_rd}), 64'({1'b1, 5'd2}));
    cycle();

    // flush in IDLE blocks a same-cycle offer
    in_valid = 1'b1; in_op = 4'd0; flush = 1'b1;
    cycle();
    in_valid = 1'b0; flush = 1'b0;
    cycle();
    chk("idle_flush_noacc", 64'({last.ldA, last.in_ready}), 64'(2'b01));

    // rst mid-EXEC of a DIV suppresses its writeback
    in_valid = 1'b1; in_op = 4'd3; in_rd = 5'd8;
    cycle();
    in_valid = 1'b0;
    cycle(); cycle(); cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_exec_clr", 64'({last.clrA, last.wb_en, last.done, last.sel}), 64'({1'b1, 1'b0, 1'b0, 3'd0}));
    cycle();

    for (int n = 0; n < 600; n++) begin
      in_valid = 1'($urandom % 2);
      in_op    = 4'($urandom % 16);
      in_imm   = 1'($urandom % 2);
      in_rd    = 5'($urandom);
      flush    = ($urandom % 20) == 0;
      rst      = ($urandom % 80) == 0;
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0;
    for (int n = 0; n < 10; n++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
